// File: rtl/game_pkg.sv
// Shared types for the game flow controller: round state encoding and map tile coordinates.
// Used by game_flow_ctrl and ghost_collide (optional build macro: COLLISION_SWAP_EN).
package game_pkg;

  localparam int unsigned MAP_W = 40;
  localparam int unsigned MAP_H = 30;

  typedef logic [5:0] tile_x_t;
  typedef logic [4:0] tile_y_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    READY    = 3'd2,
    PLAY     = 3'd3,
    DYING    = 3'd4,
    LEVEL_UP = 3'd5,
    OVER     = 3'd6
  } game_state_t;

  function automatic logic same_tile(input tile_x_t ax, input tile_y_t ay,
                                     input tile_x_t bx, input tile_y_t by);
    return (ax == bx) && (ay == by);
  endfunction

  function automatic logic on_map(input tile_x_t x, input tile_y_t y);
    return (32'(x) < MAP_W) && (32'(y) < MAP_H);
  endfunction

endpackage

// File: rtl/ghost_collide.sv
// One ghost vs pacman collision detector with a registered collision flag.
// COLLISION_SWAP_EN adds previous-position registers to catch tile swaps (pass-through).
module ghost_collide
  import game_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    eval,
  input  logic    clear,
`ifdef COLLISION_SWAP_EN
  input  logic    track,
`endif
  input  tile_x_t pac_x,
  input  tile_y_t pac_y,
  input  tile_x_t ghost_x,
  input  tile_y_t ghost_y,
  output logic    hit,
  output logic    flag
);

  logic same;
  logic swap;

  assign same = same_tile(ghost_x, ghost_y, pac_x, pac_y);

`ifdef COLLISION_SWAP_EN
  tile_x_t pac_px;
  tile_y_t pac_py;
  tile_x_t ghost_px;
  tile_y_t ghost_py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pac_px   <= '0;
      pac_py   <= '0;
      ghost_px <= '0;
      ghost_py <= '0;
    end else if (track) begin
      pac_px   <= pac_x;
      pac_py   <= pac_y;
      ghost_px <= ghost_x;
      ghost_py <= ghost_y;
    end
  end

  // Both actors stepped through each other: each now sits where the other was.
  assign swap = same_tile(ghost_px, ghost_py, pac_x, pac_y) &&
                same_tile(pac_px, pac_py, ghost_x, ghost_y);
`else
  assign swap = 1'b0;
`endif

  assign hit = eval && (same || swap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (clear) begin
      flag <= 1'b0;
    end else begin
      flag <= hit;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Round lifecycle sequencer: map reload, ready countdown, play, death freeze, level clear, game over.
// Optional build macro COLLISION_SWAP_EN enables swap (pass-through) collision detection.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned N_GHOSTS        = 2,
  parameter int unsigned MAX_LIVES       = 3,
  parameter int unsigned PILLS_PER_LEVEL = 300,
  parameter int unsigned READY_CYCLES    = 100_000_000,
  parameter int unsigned DEATH_CYCLES    = 75_000_000,
  parameter int unsigned PILL_POINTS     = 10,
  parameter int unsigned SCORE_W         = 16,
  parameter int unsigned LEVEL_W         = 4
) (
  input  logic                              CLOCK_50,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              game_reset,
  input  logic [5:0]                        pac_x,
  input  logic [4:0]                        pac_y,
  input  logic [6*N_GHOSTS-1:0]             ghost_x,
  input  logic [5*N_GHOSTS-1:0]             ghost_y,
  input  logic                              pill_eaten,
  input  logic                              map_load_done,
  output logic                              map_load_req,
  output logic                              core_reset,
  output logic                              map_wr_reset,
  output logic                              ghost_enable,
  output logic [$clog2(MAX_LIVES+1)-1:0]    lives,
  output logic [LEVEL_W-1:0]                level,
  output logic [SCORE_W-1:0]                score,
  output logic [N_GHOSTS-1:0]               collide_mask,
  output logic                              game_over,
  output logic [2:0]                        state_o
);

  localparam int unsigned LIVES_W = $clog2(MAX_LIVES + 1);
  localparam int unsigned TMR_MAX = (READY_CYCLES > DEATH_CYCLES) ? READY_CYCLES : DEATH_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned PILL_W  = $clog2(PILLS_PER_LEVEL + 1);

  game_state_t         state_q;
  game_state_t         state_d;
  logic [TMR_W-1:0]    timer;
  logic [PILL_W-1:0]   pills;
  logic [N_GHOSTS-1:0] hit;
  logic                hit_any;
  logic                in_play;
  logic                ready_done;
  logic                death_done;
  logic                pills_full;
  logic [SCORE_W:0]    score_sum;

  assign in_play    = (state_q == PLAY);
  assign hit_any    = |hit;
  assign ready_done = (timer == TMR_W'(READY_CYCLES - 1));
  assign death_done = (timer == TMR_W'(DEATH_CYCLES - 1));
  assign pills_full = (pills == PILL_W'(PILLS_PER_LEVEL));
  assign score_sum  = {1'b0, score} + (SCORE_W+1)'(PILL_POINTS);
  assign state_o    = state_q;

`ifdef COLLISION_SWAP_EN
  logic track;
  assign track = in_play || ((state_q == READY) && (state_d == PLAY));
`endif

  for (genvar g = 0; g < N_GHOSTS; g++) begin : g_ghost
    ghost_collide u_collide (
      .clk     (CLOCK_50),
      .rst_n   (reset_n),
      .eval    (in_play),
      .clear   (game_reset),
`ifdef COLLISION_SWAP_EN
      .track   (track),
`endif
      .pac_x   (pac_x),
      .pac_y   (pac_y),
      .ghost_x (ghost_x[6*g +: 6]),
      .ghost_y (ghost_y[5*g +: 5]),
      .hit     (hit[g]),
      .flag    (collide_mask[g])
    );
  end

  // Collision is tested before the pill counter so a simultaneous last pill
  // leaves the counter full and the level clears on the next PLAY entry.
  always_comb begin
    state_d = state_q;
    if (game_reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start) state_d = LOAD;
        LOAD:     if (map_load_done) state_d = READY;
        READY:    if (ready_done) state_d = PLAY;
        PLAY: begin
          if (hit_any)         state_d = DYING;
          else if (pills_full) state_d = LEVEL_UP;
        end
        DYING:    if (death_done) state_d = (lives == '0) ? OVER : READY;
        LEVEL_UP: state_d = LOAD;
        OVER:     state_d = OVER;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    core_reset   = 1'b0;
    map_wr_reset = 1'b0;
    ghost_enable = 1'b0;
    game_over    = 1'b0;
    case (state_q)
      IDLE: begin
        core_reset   = 1'b1;
        map_wr_reset = 1'b1;
      end
      LOAD:     core_reset = 1'b1;
      READY:    core_reset = (timer == '0);
      PLAY:     ghost_enable = 1'b1;
      LEVEL_UP: core_reset = 1'b1;
      OVER:     game_over = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      map_load_req <= 1'b0;
      timer        <= '0;
      pills        <= '0;
      lives        <= LIVES_W'(MAX_LIVES);
      level        <= '0;
      score        <= '0;
    end else begin
      state_q      <= state_d;
      map_load_req <= (state_d == LOAD) && (state_q != LOAD);
      if (game_reset || (state_q == IDLE)) begin
        timer <= '0;
        pills <= '0;
        lives <= LIVES_W'(MAX_LIVES);
        level <= '0;
        score <= '0;
      end else begin
        case (state_q)
          READY, DYING: timer <= (state_d == state_q) ? timer + 1'b1 : '0;
          default:      timer <= '0;
        endcase
        if (in_play) begin
          if (pill_eaten) begin
            score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (!pills_full) pills <= pills + 1'b1;
          end
          if (hit_any && (lives != '0)) lives <= lives - 1'b1;
        end
        if (state_q == LEVEL_UP) begin
          pills <= '0;
          if (level != '1) level <= level + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised successor to the top-level two-state init/game sequencer.
- Owns the full round lifecycle: map reload handshake, ready countdown, play, death freeze, level clear, game over.
- Detects pacman/ghost collisions across N_GHOSTS channels and counts pills, lives, level and score.
- Sits beside map_RAM_writer, pacman_loc_ctrl and ghosts_ai, and drives their resets and the ghost enable.

Parameters:
- N_GHOSTS, 2, number of ghost position channels (1..8).
- MAX_LIVES, 3, lives loaded at game start.
- PILLS_PER_LEVEL, 300, pill_eaten pulses that clear a level.
- READY_CYCLES, 100_000_000, PLAY entry delay in clocks (2 s at 50 MHz).
- DEATH_CYCLES, 75_000_000, freeze length after a collision.
- PILL_POINTS, 10, score added per pill.
- SCORE_W, 16, score width.
- LEVEL_W, 4, level width.

Ports:
- CLOCK_50 input 1: system clock.
- reset_n input 1: asynchronous active-low reset.
- start input 1: level-sensitive start request (SW[9]).
- game_reset input 1: synchronous return to IDLE (SW[0]).
- pac_x input 6: pacman tile x (0..39).
- pac_y input 5: pacman tile y (0..29).
- ghost_x input 6*N_GHOSTS: packed ghost x; channel i at [6i+:6].
- ghost_y input 5*N_GHOSTS: packed ghost y; channel i at [5i+:5].
- pill_eaten input 1: one-cycle pulse per pill consumed.
- map_load_done input 1: map writer finished reloading the map.
- map_load_req output 1: pulse requesting a map reload.
- core_reset output 1: active-high reset to pacman/ghost controllers.
- map_wr_reset output 1: active-high reset to map writer.
- ghost_enable output 1: ghosts may move.
- lives output $clog2(MAX_LIVES+1): remaining lives.
- level output LEVEL_W: current level.
- score output SCORE_W: current score.
- collide_mask output N_GHOSTS: registered per-ghost collision flags.
- game_over output 1: high in OVER.
- state_o output 3: encoded state, for debug/HEX.

Behaviour:
- Reset (reset_n low, async), then state IDLE with these values:
  - core_reset=1, map_wr_reset=1, ghost_enable=0, map_load_req=0.
  - lives=MAX_LIVES, level=0, score=0, collide_mask=0, game_over=0.
  - All timers and the pill counter are 0.
- game_reset=1 in any state → IDLE next cycle with the same values. game_reset has priority over every other transition.
- States and transitions:
  - IDLE: resets asserted. start=1 → LOAD; map_load_req pulses for one cycle on entry to LOAD.
  - LOAD: map_wr_reset=0, core_reset=1. map_load_done=1 → READY and timer cleared. No timeout; waits indefinitely.
  - READY: core_reset=1 for the first cycle only, then 0. ghost_enable=0. Timer counts up; at READY_CYCLES-1 → PLAY.
  - PLAY: core_reset=0, ghost_enable=1.
    - Any collision → DYING, timer cleared.
    - Otherwise pill counter reaching PILLS_PER_LEVEL → LEVEL_UP.
  - DYING: ghost_enable=0, lives decremented once on entry.
    - Timer reaches DEATH_CYCLES-1 with lives=0 after the decrement → OVER.
    - Otherwise → READY; positions are reset via core_reset, the map is not reloaded.
  - LEVEL_UP: level+1 (saturates at 2^LEVEL_W-1), pill counter cleared, map_load_req pulse → LOAD.
  - OVER: game_over=1, outputs frozen. Exit only via game_reset or reset_n.
- Collision: collide_mask[i] is registered, 1 cycle after positions match: (ghost_x[i]==pac_x && ghost_y[i]==pac_y). It is evaluated only in PLAY and is 0 elsewhere.
- Pills: a pill_eaten pulse counts only in PLAY.
  - score += PILL_POINTS, saturating at all-ones.
  - Pills ignored outside PLAY.
- Simultaneous collision and last pill in the same cycle: collision wins. The pill is still scored, the level does not advance, and the counter holds at PILLS_PER_LEVEL. The level clears on the first PLAY cycle after READY.
- Lives never underflow: decrement only when lives>0.

Optional Feature:
- COLLISION_SWAP_EN defined:
  - Additionally registers the previous pacman and ghost positions.
  - Flags collision when the two swapped tiles in one step (ghost_prev==pac_now && pac_prev==ghost_now), catching pass-through.
  - Previous-position registers reload on every READY→PLAY entry.
- Undefined: same-tile check only; no extra registers.

Decomposition:
- Shared package game_pkg holds:
  - the state enum (IDLE, LOAD, READY, PLAY, DYING, LEVEL_UP, OVER);
  - MAP_W=40, MAP_H=30;
  - the tile coordinate typedefs (6-bit x, 5-bit y).
- One natural sub-module: ghost_collide, one instance per channel via generate. It compares one ghost against pacman and, when COLLISION_SWAP_EN is defined, holds the previous-position registers.

Test Plan:
- reset_n low mid-PLAY with score=40 → same cycle: lives=3, score=0, state_o=IDLE, core_reset=1.
- start=1, map_load_done after 5 cycles, READY_CYCLES=10 (bench override) → PLAY exactly 10 cycles after READY entry, ghost_enable=1.
- PILLS_PER_LEVEL=4, four pill_eaten pulses in PLAY → score=40, level=1, map_load_req pulse, state LOAD.
- ghost 1 at pac tile (12,7) in PLAY → collide_mask=2'b10 next cycle, DYING, lives=2. After DEATH_CYCLES → READY.
- Three collisions with MAX_LIVES=3 → OVER, game_over=1; start ignored; game_reset → IDLE, lives=3.
- COLLISION_SWAP_EN: pac (5,5)→(6,5) while ghost (6,5)→(5,5) → DYING. Without the macro → stays PLAY.
